// File: rtl/md5_wb_master_if.sv
// rtl/md5_wb_master_if.sv - Wishbone single-transfer bus between the MD5 initiator and the MD5 slave
interface md5_wb_master_if #(
  parameter int AW = 32
);
  logic [AW-1:0] wbm_adr_o;
  logic [31:0]   wbm_dat_o;
  logic [31:0]   wbm_dat_i;
  logic [3:0]    wbm_sel_o;
  logic          wbm_we_o;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_ack_i;
  logic          wbm_err_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/md5_wb_master.sv
// rtl/md5_wb_master.sv - Wishbone initiator that hashes one pre-padded 512-bit block on the MD5 slave
module md5_wb_master #(
  parameter int            AW         = 32,
  parameter logic [AW-1:0] BASE_ADDR  = '0,
  parameter int            POLL_LIMIT = 4096
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           blk_valid,
  output logic           blk_ready,
  input  logic           blk_first,
  input  logic [511:0]   blk_data,
  output logic           dig_valid,
  input  logic           dig_ready,
  output logic [127:0]   dig_data,
  output logic           dig_err,
  output logic           busy_o,
  md5_wb_master_if.master wbm
);
  typedef enum logic [3:0] {
    IDLE, RST_HI, RST_LO, POLL_RDY, LOAD, START_HI, START_LO, POLL_DONE, READ, DONE
  } state_t;

  state_t         state, state_n;
  logic           cyc_q, we_q;
  logic [AW-1:0]  adr_q;
  logic [31:0]    dat_q;
  logic [511:0]   blk_q;
  logic [4:0]     widx;
  logic [1:0]     ridx;
  logic [31:0]    poll_cnt;
  logic [127:0]   dig_q;
  logic           err_q;

  logic           op_done, op_ok, bus_state, poll_hit, poll_last;
  logic [4:0]     op_k;
  logic           op_we;
  logic [31:0]    op_dat;
  logic [9:0]     load_lsb;

  assign op_done   = cyc_q & (wbm.wbm_ack_i | wbm.wbm_err_i);
  assign op_ok     = op_done & ~wbm.wbm_err_i;
  assign poll_hit  = wbm.wbm_dat_i[0];
  assign poll_last = (poll_cnt == 32'(POLL_LIMIT - 1));
  assign load_lsb  = {widx - 5'd1, 5'd0};

  // Register operation the current state wants on the bus
  always_comb begin
    op_k      = 5'd0;
    op_we     = 1'b0;
    op_dat    = 32'd0;
    bus_state = 1'b1;
    case (state)
      RST_HI:    begin op_k = 5'd22; op_we = 1'b1; op_dat = 32'd1; end
      RST_LO:    begin op_k = 5'd22; op_we = 1'b1; end
      POLL_RDY:  op_k = 5'd0;
      LOAD:      begin op_k = widx; op_we = 1'b1; op_dat = blk_q[load_lsb +: 32]; end
      START_HI:  begin op_k = 5'd0; op_we = 1'b1; op_dat = 32'd1; end
      START_LO:  begin op_k = 5'd0; op_we = 1'b1; end
      POLL_DONE: op_k = 5'd17;
      READ:      op_k = 5'd21 - {3'b000, ridx};
      default:   bus_state = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (blk_valid) state_n = blk_first ? RST_HI : POLL_RDY;
      DONE: if (dig_ready) state_n = IDLE;
      default: begin
        if (op_done && wbm.wbm_err_i) begin
          state_n = DONE;
        end else if (op_ok) begin
          case (state)
            RST_HI:    state_n = RST_LO;
            RST_LO:    state_n = POLL_RDY;
            POLL_RDY:  if (poll_hit) state_n = LOAD; else if (poll_last) state_n = DONE;
            LOAD:      if (widx == 5'd16) state_n = START_HI;
            START_HI:  state_n = START_LO;
            START_LO:  state_n = POLL_DONE;
            POLL_DONE: if (poll_hit) state_n = READ; else if (poll_last) state_n = DONE;
            READ:      if (ridx == 2'd3) state_n = DONE;
            default:   state_n = state;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      blk_q    <= '0;
      widx     <= 5'd1;
      ridx     <= 2'd0;
      poll_cnt <= '0;
      dig_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      // Issue only from an idle bus so every op is followed by one dead cycle
      if (op_done) begin
        cyc_q <= 1'b0;
        we_q  <= 1'b0;
        adr_q <= '0;
        dat_q <= '0;
      end else if (bus_state && !cyc_q) begin
        cyc_q <= 1'b1;
        we_q  <= op_we;
        adr_q <= BASE_ADDR + AW'({op_k, 2'b00});
        dat_q <= op_dat;
      end
      if (state == IDLE && blk_valid) begin
        blk_q <= blk_data;
        widx  <= 5'd1;
        ridx  <= 2'd0;
        dig_q <= '0;
        err_q <= 1'b0;
      end
      if (state_n != state) poll_cnt <= '0;
      else if (op_done)     poll_cnt <= poll_cnt + 32'd1;
      if (op_done && wbm.wbm_err_i) begin
        err_q <= 1'b1;
        dig_q <= '0;
      end else if (op_ok) begin
        case (state)
          LOAD: widx <= widx + 5'd1;
          READ: begin
            dig_q[(7'd96 - {ridx, 5'd0}) +: 32] <= wbm.wbm_dat_i;
            ridx <= ridx + 2'd1;
          end
          POLL_RDY, POLL_DONE: if (!poll_hit && poll_last) err_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_sel_o = cyc_q ? 4'hF : 4'h0;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign wbm.wbm_we_o  = we_q;

  assign blk_ready = (state == IDLE) && !wb_rst_i;
  assign dig_valid = (state == DONE);
  assign dig_data  = dig_q;
  assign dig_err   = err_q;
  assign busy_o    = (state != IDLE);
endmodule
